quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, the number of consecutive stable samples (range 1-15) needed to accept an input level.
REQ-002 SHALL have parameter VEL_WIN_LOG2, default 16; the velocity window is 2^VEL_WIN_LOG2 clk cycles.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 enc_a, enc_b  in  1 each  raw quadrature encoder channels, asynchronous to clk.
REQ-006 avs_s0_address  in  2  Avalon-MM slave word address.
REQ-007 avs_s0_read, avs_s0_write  in  1 each  Avalon-MM strobes; zero wait states.
REQ-008 avs_s0_writedata  in  32  write data.
REQ-009 avs_s0_readdata  out  32  combinational read data.
REQ-010 count  out  8  position[7:0], feeding the downstream count consumer.
REQ-011 dir  out  1  direction of the last valid step: 1 = forward, 0 = reverse.
REQ-012 err  out  1  sticky illegal-transition flag.

Function
REQ-013 Each encoder input SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Glitch filter, per channel:
- A per-channel run counter tracks how long the synchronized level has differed from the filtered level.
- The filtered level SHALL change only after the synchronized level has held the new value for FILTER_LEN consecutive cycles.
- Any return to the old level resets the counter.
REQ-015 Decoder state = filtered {A,B}. Gray sequence 00->01->11->10->00 SHALL be +1; the reverse sequence SHALL be -1. Both bits changing in the same cycle SHALL set err and leave position unchanged.
REQ-016 position SHALL be a 16-bit two's-complement register that wraps silently (0x7FFF+1 -> 0x8000, 0x0000-1 -> 0xFFFF).
REQ-017 Latency: count/position SHALL update on the cycle after the filtered state changes; total pin-to-count latency is 2 + FILTER_LEN + 1 cycles.
REQ-018 Steps SHALL be counted only while ctrl.enable = 1. While disabled:
- filtering and state tracking continue;
- no step is counted and err is not set.
REQ-019 Register map:
- addr0, read: position sign-extended to 32 bits; write: ignored.
- addr1, read: {29'b0, err, dir, enable}; write: bit0 sets enable, bit1 clears position, bit2 clears err (bits 1 and 2 self-clearing).
- addr2, write: position <= writedata[15:0] (preload); read: 0.
- addr3, read: velocity (see REQ-026) or 0; write: ignored.
REQ-020 avs_s0_readdata SHALL be 0 whenever avs_s0_read = 0.
REQ-021 A clear or preload write in the same cycle as a decode step SHALL win; that step is discarded.
REQ-022 If a clear-err write coincides with a new illegal transition, err SHALL remain 1.
REQ-023 dir SHALL update only on valid counted steps.

Reset
REQ-024 On reset low, all of the following SHALL take their values asynchronously:
- position = 0, count = 0, dir = 0, err = 0, enable = 0;
- synchronizers, filtered levels and run counters = 0;
- velocity registers = 0.
REQ-025 Reset asserted mid-step SHALL discard any pending step. After release, the first filtered state is taken as the baseline and is not counted.

Configuration
REQ-026 Macro QUAD_DECODER_VELOCITY_EN.
- Defined: a window timer counts 2^VEL_WIN_LOG2 cycles while a signed 16-bit accumulator sums counted steps. At each window end the accumulator is latched into velocity and cleared; a step landing on the latch cycle belongs to the new window. Accumulator saturates at +/-32767. addr3 reads velocity sign-extended to 32 bits.
- Undefined: no timer, accumulator or velocity logic exists, and addr3 reads 0.

Verification
REQ-027 Reset, enable=1, drive 8 forward Gray steps, each held 10 cycles -> position = 8, count = 0x08, dir = 1, err = 0.
REQ-028 Preload 0x0000, then 1 reverse step -> addr0 reads 0xFFFFFFFF, count = 0xFF, dir = 0.
REQ-029 2-cycle pulse on enc_a with FILTER_LEN = 4 -> no state change and position unchanged; the same pulse held 5 cycles is accepted.
REQ-030 Flip A and B together from 00 to 11 -> err = 1 with position unchanged; write addr1 = 0x5 -> err = 0 and enable stays 1.
REQ-031 Preload 0x7FFF and a forward step in the same cycle -> position = 0x7FFF. Next forward step -> 0x8000 (wrap).
REQ-032 With QUAD_DECODER_VELOCITY_EN and VEL_WIN_LOG2 = 8, 12 forward steps in one window -> addr3 reads 12 after the window ends. Without the macro -> addr3 reads 0.

Source files
------------

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder decoder with glitch filter, 16-bit position
// counter and Avalon-MM slave register access.
// Optional feature macro: QUAD_DECODER_VELOCITY_EN (window-based velocity
// measurement readable at address 3; reads 0 when the macro is undefined).
module quad_decoder #(
  parameter int FILTER_LEN   = 4,
  parameter int VEL_WIN_LOG2 = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic [7:0]  count,
  output logic        dir,
  output logic        err
);

  if (FILTER_LEN < 1 || FILTER_LEN > 15 || VEL_WIN_LOG2 < 1) begin : g_param_chk
    $error("quad_decoder: FILTER_LEN must be 1..15 and VEL_WIN_LOG2 >= 1");
  end

  localparam logic [3:0] RUN_MAX = 4'(FILTER_LEN - 1);
  // Steps are ignored until a freshly reset synchronizer/filter chain has
  // had time to settle; the state seen then becomes the uncounted baseline.
  localparam logic [4:0] WARM    = 5'(FILTER_LEN + 4);

  // Bit 1 = channel A, bit 0 = channel B throughout.
  logic [1:0]      s1_q, s1_d, s2_q, s2_d;
  logic [1:0]      filt_q, filt_d, prev_q, prev_d;
  logic [1:0][3:0] run_q, run_d;
  logic [4:0]      warm_q, warm_d;
  logic [15:0]     pos_q, pos_d;
  logic            dir_q, dir_d, err_q, err_d, en_q, en_d;

  logic [1:0] delta;
  logic       armed, step_fwd, step_rev, step_ill, counted;
  logic       wr_ctrl, clr_pos, clr_err, preload;
  logic [31:0] vel_rd;
  logic       unused_wdata;

  assign unused_wdata = ^avs_s0_writedata[31:16];

  // Gray code to 2-bit binary phase so a step is a +/-1 phase difference.
  function automatic logic [1:0] g2b(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Synchronizers, per-channel run-length glitch filter and warm-up counter.
  always_comb begin
    s1_d   = {enc_a, enc_b};
    s2_d   = s1_q;
    prev_d = filt_q;
    warm_d = (warm_q == WARM) ? warm_q : warm_q + 5'd1;
    for (int i = 0; i < 2; i++) begin
      run_d[i]  = 4'd0;
      filt_d[i] = filt_q[i];
      if (s2_q[i] != filt_q[i]) begin
        if (run_q[i] == RUN_MAX) filt_d[i] = s2_q[i];
        else                     run_d[i]  = run_q[i] + 4'd1;
      end
    end
  end

  assign armed    = (warm_q == WARM);
  assign delta    = g2b(filt_q) - g2b(prev_q);
  assign step_fwd = armed && en_q && (delta == 2'd1);
  assign step_rev = armed && en_q && (delta == 2'd3);
  assign step_ill = armed && en_q && (delta == 2'd2);

  assign wr_ctrl  = avs_s0_write && (avs_s0_address == 2'd1);
  assign clr_pos  = wr_ctrl && avs_s0_writedata[1];
  assign clr_err  = wr_ctrl && avs_s0_writedata[2];
  assign preload  = avs_s0_write && (avs_s0_address == 2'd2);
  // A bus clear/preload in the same cycle overrides the decoded step.
  assign counted  = (step_fwd || step_rev) && !clr_pos && !preload;

  // Position, direction, sticky error and enable next-state.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    err_d = err_q;
    en_d  = en_q;
    if (clr_pos)       pos_d = 16'd0;
    else if (preload)  pos_d = avs_s0_writedata[15:0];
    else if (step_fwd) pos_d = pos_q + 16'd1;
    else if (step_rev) pos_d = pos_q - 16'd1;
    if (counted) dir_d = step_fwd;
    if (step_ill)     err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    if (wr_ctrl) en_d = avs_s0_writedata[0];
  end

  // Core state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      prev_q <= '0;
      run_q  <= '0;
      warm_q <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      run_q  <= run_d;
      warm_q <= warm_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
      en_q   <= en_d;
    end
  end

`ifdef QUAD_DECODER_VELOCITY_EN
  logic [VEL_WIN_LOG2-1:0] tmr_q, tmr_d;
  logic signed [15:0]      acc_q, acc_d, vel_q, vel_d, acc_base;
  logic                    win_end;

  assign win_end  = (tmr_q == '1);
  // A step on the latch cycle starts the new window's sum.
  assign acc_base = win_end ? 16'sd0 : acc_q;

  // Window timer and saturating step accumulator.
  always_comb begin
    tmr_d = tmr_q + 1'b1;
    vel_d = win_end ? acc_q : vel_q;
    acc_d = acc_base;
    if (counted && step_fwd && acc_base != 16'sd32767)       acc_d = acc_base + 16'sd1;
    else if (counted && step_rev && acc_base != -16'sd32767) acc_d = acc_base - 16'sd1;
  end

  // Velocity registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q <= '0;
      acc_q <= '0;
      vel_q <= '0;
    end else begin
      tmr_q <= tmr_d;
      acc_q <= acc_d;
      vel_q <= vel_d;
    end
  end

  assign vel_rd = {{16{vel_q[15]}}, vel_q};
`else
  assign vel_rd = 32'd0;
`endif

  // Zero-wait-state read mux; idle bus reads as zero.
  always_comb begin
    avs_s0_readdata = 32'd0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        2'd0:    avs_s0_readdata = {{16{pos_q[15]}}, pos_q};
        2'd1:    avs_s0_readdata = {29'd0, err_q, dir_q, en_q};
        2'd2:    avs_s0_readdata = 32'd0;
        default: avs_s0_readdata = vel_rd;
      endcase
    end
  end

  assign count = pos_q[7:0];
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven, hand-sequenced and randomized checks of
// quad_decoder against a phase/position model kept in plain integers.
module tb_quad_decoder;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enc_a = 1'b0, enc_b = 1'b0;
  logic [1:0]  avs_s0_address = 2'd0;
  logic        avs_s0_read = 1'b0, avs_s0_write = 1'b0;
  logic [31:0] avs_s0_writedata = 32'd0;
  logic [31:0] avs_s0_readdata;
  logic [7:0]  count;
  logic        dir, err;

  quad_decoder #(.FILTER_LEN(FL), .VEL_WIN_LOG2(8)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .avs_s0_address(avs_s0_address), .avs_s0_read(avs_s0_read),
    .avs_s0_write(avs_s0_write), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata(avs_s0_readdata), .count(count), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  localparam int OP_FWD = 0, OP_REV = 1, OP_GLI = 2, OP_ILL = 3, OP_WR1 = 4, OP_PRE = 5;

  typedef struct {
    int op;
    int arg;
    int pos;
    bit dir;
    bit err;
  } vec_t;

  int tests = 0, fails = 0;
  int ph = 0;          // encoder phase 0..3 along the forward Gray sequence
  int m_pos = 0;       // model position 0..65535
  bit m_dir = 0, m_err = 0, m_en = 0;
  int chg = 0;         // number of observed count changes
  logic [7:0] cnt_prev = 8'd0;

  // Count every change of the count output, sampled away from the clock edge.
  always @(negedge clk) begin
    if (count !== cnt_prev) chg <= chg + 1;
    cnt_prev <= count;
  end

  function automatic logic [1:0] gray(input int p);
    case (p)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int wrap16(input int v);
    return ((v % 65536) + 65536) % 65536;
  endfunction

  function automatic logic [31:0] sx(input int v);
    return (v >= 32768) ? 32'(v - 65536) : 32'(v);
  endfunction

  function automatic vec_t mk(input int op, input int arg, input int pos, input bit d, input bit e);
    vec_t v;
    v.op = op; v.arg = arg; v.pos = pos; v.dir = d; v.err = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
    @(negedge clk);
    avs_s0_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_s0_address = a; avs_s0_read = 1'b1;
    #1 d = avs_s0_readdata;
    avs_s0_read = 1'b0;
  endtask

  task automatic drive();
    @(negedge clk);
    {enc_a, enc_b} = gray(ph);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
  endtask

  task automatic do_op(input int op, input int arg);
    int q;
    case (op)
      OP_FWD: begin
        ph = (ph + 1) % 4; drive(); settle();
        if (m_en) begin m_pos = wrap16(m_pos + 1); m_dir = 1; end
      end
      OP_REV: begin
        ph = (ph + 3) % 4; drive(); settle();
        if (m_en) begin m_pos = wrap16(m_pos - 1); m_dir = 0; end
      end
      OP_GLI: begin
        // Pulse channel A away and back; if long enough it is two opposite steps.
        q = 0;
        for (int k = 0; k < 4; k++) if (gray(k) == (gray(ph) ^ 2'b10)) q = k;
        @(negedge clk); enc_a = ~enc_a;
        repeat (arg) @(negedge clk);
        enc_a = ~enc_a;
        settle();
        if (m_en && arg >= FL) m_dir = (((ph - q) % 4 + 4) % 4) == 1;
      end
      OP_ILL: begin
        ph = (ph + 2) % 4; drive(); settle();
        if (m_en) m_err = 1;
      end
      OP_WR1: begin
        wr(2'd1, 32'(arg));
        m_en = arg[0];
        if (arg[1]) m_pos = 0;
        if (arg[2]) m_err = 0;
      end
      default: begin
        wr(2'd2, 32'(arg));
        m_pos = arg & 16'hFFFF;
      end
    endcase
  endtask

  task automatic check_state(input string nm, input int pos, input bit d, input bit e);
    logic [31:0] r;
    rd(2'd0, r);
    chk({nm, ".addr0"}, r, sx(pos));
    chk({nm, ".count"}, {24'd0, count}, 32'(pos % 256));
    chk({nm, ".dir"}, {31'd0, dir}, {31'd0, d});
    chk({nm, ".err"}, {31'd0, err}, {31'd0, e});
  endtask

  task automatic check_model(input string nm);
    logic [31:0] r;
    check_state(nm, m_pos, m_dir, m_err);
    rd(2'd1, r);
    chk({nm, ".addr1"}, r, {29'd0, m_err, m_dir, m_en});
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] r;
    logic [7:0]  c0;
    int lat, c_before, op, arg;

    // Directed vectors, expectations worked out by hand from reset state.
    tbl.push_back(mk(OP_WR1, 1, 0, 0, 0));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(OP_FWD, 0, i, 1, 0));
    tbl.push_back(mk(OP_PRE, 0, 0, 1, 0));
    tbl.push_back(mk(OP_REV, 0, 65535, 0, 0));
    tbl.push_back(mk(OP_GLI, 2, 65535, 0, 0));
    tbl.push_back(mk(OP_GLI, 3, 65535, 0, 0));
    tbl.push_back(mk(OP_ILL, 0, 65535, 0, 1));
    tbl.push_back(mk(OP_WR1, 5, 65535, 0, 0));
    tbl.push_back(mk(OP_FWD, 0, 0, 1, 0));
    tbl.push_back(mk(OP_WR1, 0, 0, 1, 0));
    tbl.push_back(mk(OP_FWD, 0, 0, 1, 0));
    tbl.push_back(mk(OP_ILL, 0, 0, 1, 0));
    tbl.push_back(mk(OP_WR1, 1, 0, 1, 0));
    tbl.push_back(mk(OP_REV, 0, 65535, 0, 0));
    tbl.push_back(mk(OP_WR1, 3, 0, 0, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.count", {24'd0, count}, 32'd0);
    chk("rst.dir", {31'd0, dir}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (20) @(posedge clk);
    rd(2'd0, r); chk("rst.addr0", r, 32'd0);
    rd(2'd1, r); chk("rst.addr1", r, 32'd0);
    rd(2'd3, r); chk("rst.addr3", r, 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i].op, tbl[i].arg);
      check_state($sformatf("vec%0d", i), tbl[i].pos, tbl[i].dir, tbl[i].err);
    end

    // Short pulse rejected, pulse held FILTER_LEN+1 cycles accepted.
    c_before = chg;
    do_op(OP_GLI, 2);
    chk("glitch2.changes", 32'(chg - c_before), 32'd0);
    c_before = chg;
    do_op(OP_GLI, 5);
    chk("glitch5.changes", 32'(chg - c_before), 32'd2);
    check_model("glitch5");

    // Pin-to-count latency of one step.
    ph = (ph + 1) % 4; drive();
    c0 = count; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (lat == 0 && count !== c0) lat = i;
    end
    chk("latency", 32'(lat), 32'(2 + FL + 1));
    m_pos = wrap16(m_pos + 1); m_dir = 1;
    settle();

    // Preload coincident with a step wins; the next step wraps to 0x8000.
    ph = (ph + 1) % 4; drive();
    repeat (6) @(posedge clk);
    wr(2'd2, 32'h7FFF);
    settle();
    m_pos = 32'h7FFF;
    check_model("preload_win");
    do_op(OP_FWD, 0);
    rd(2'd0, r); chk("wrap.addr0", r, 32'hFFFF8000);
    check_model("wrap");
    @(negedge clk); avs_s0_address = 2'd0; #1;
    chk("idle_read", avs_s0_readdata, 32'd0);

    // Clear-err coincident with a new illegal transition keeps err set.
    ph = (ph + 2) % 4; drive();
    repeat (6) @(posedge clk);
    wr(2'd1, 32'h5);
    settle();
    m_err = 1;
    check_model("clr_vs_ill");
    do_op(OP_WR1, 5);
    check_model("clr_err");

    // Reset in the middle of a step; the post-reset state is only a baseline.
    ph = (ph + 1) % 4; drive();
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("midrst.count", {24'd0, count}, 32'd0);
    @(negedge clk) reset = 1'b1;
    m_pos = 0; m_dir = 0; m_err = 0; m_en = 0;
    repeat (30) @(posedge clk);
    check_model("midrst");
    do_op(OP_WR1, 1);

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 7);
      if (op > OP_PRE) op = op - 6;          // bias toward steps
      case (op)
        OP_GLI:  arg = $urandom_range(1, 3);
        OP_WR1:  arg = $urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 1 : 0);
        OP_PRE:  arg = $urandom_range(0, 65535);
        default: arg = 0;
      endcase
      do_op(op, arg);
      check_model($sformatf("rnd%0d", i));
    end

`ifdef QUAD_DECODER_VELOCITY_EN
    // Fresh reset fixes the window phase; 12 steps fit in the first window.
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    m_pos = 0; m_dir = 0; m_err = 0; m_en = 0;
    repeat (10) @(posedge clk);
    do_op(OP_WR1, 1);
    for (int i = 0; i < 12; i++) do_op(OP_FWD, 0);
    repeat (150) @(posedge clk);
    rd(2'd3, r); chk("velocity", r, 32'd12);
`else
    rd(2'd3, r); chk("velocity_off", r, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
